// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the RV32M divide sequencer.
//   - op encodings carried on in_op
//   - sequencer state encoding
//   - RISC-V special-case quotient constants
//   - small op-decoding helpers
package div_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_TAG_W = 5;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

    // Quotient returned for divide-by-zero and for signed overflow (MIN / -1).
    localparam logic [DIV_XLEN-1:0] DIV0_QUOT = '1;
    localparam logic [DIV_XLEN-1:0] OVF_QUOT  = 32'h8000_0000;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_if.sv
// div_if: request/response bundle between the execute stage and the divide
// sequencer.
//   request : in_valid, in_ready, in_op, in_a, in_b, in_tag
//   control : flush (abort), busy (hazard-unit stall)
//   response: out_valid, out_ready, out_result, out_tag
// master = pipeline side, slave = div_sequencer.
interface div_if
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = DIV_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem      : partial remainder from the previous step
//   dvd_bit  : next dividend bit, shifted in at the bottom
//   divisor  : unsigned divisor
//   rem_next : partial remainder after the step
//   q_bit    : quotient bit produced by this step
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);
    // The shift keeps the bit that falls off the top so the compare stays
    // exact even for divisors with the MSB set.
    logic [XLEN:0] shifted;

    always_comb begin
        shifted  = {rem, dvd_bit};
        q_bit    = (shifted >= {1'b0, divisor});
        // The difference is below divisor, so XLEN bits hold it exactly.
        rem_next = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
    end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M divider control (DIV, DIVU, REM, REMU).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : div_if slave port (request handshake, flush, busy,
//                result handshake)
// Flow: IDLE -accept-> PREP -> CALC (XLEN steps) -> FIX -> DONE -> IDLE.
// Divide-by-zero and signed overflow short-circuit PREP -> DONE.
module div_sequencer
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = DIV_TAG_W
) (
    input logic  clk,
    input logic  rst_n,
    div_if.slave bus
);
    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state;
    logic [1:0]       op;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  dvd;
    logic [XLEN-1:0]  dvs;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quot;
    logic [CNT_W-1:0] count;
    logic             neg_q;
    logic             neg_r;

    logic             signed_op;
    logic [XLEN-1:0]  a_abs;
    logic [XLEN-1:0]  b_abs;
    logic [XLEN-1:0]  step_rem;
    logic             step_q;

    // Magnitudes for signed ops; MIN_NEG maps onto itself, which is the
    // correct unsigned magnitude.
    always_comb begin
        signed_op = op_is_signed(op);
        a_abs     = (signed_op && a_q[XLEN-1]) ? -a_q : a_q;
        b_abs     = (signed_op && b_q[XLEN-1]) ? -b_q : b_q;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .dvd_bit  (dvd[count]),
        .divisor  (dvs),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            op             <= '0;
            a_q            <= '0;
            b_q            <= '0;
            dvd            <= '0;
            dvs            <= '0;
            rem            <= '0;
            quot           <= '0;
            count          <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.out_result <= '0;
            bus.out_tag    <= '0;
        end else if (bus.flush) begin
            // Abort wins over both handshakes; nothing is emitted.
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op           <= bus.in_op;
                        a_q          <= bus.in_a;
                        b_q          <= bus.in_b;
                        bus.out_tag  <= bus.in_tag;
                        state        <= ST_PREP;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                ST_PREP: begin
                    if (b_q == '0) begin
                        quot           <= DIV0_QUOT;
                        rem            <= a_q;
                        bus.out_result <= op_is_rem(op) ? a_q : DIV0_QUOT;
                        bus.out_valid  <= 1'b1;
                        state          <= ST_DONE;
                    end else if (signed_op && (a_q == MIN_NEG) && (b_q == '1)) begin
                        quot           <= OVF_QUOT;
                        rem            <= '0;
                        bus.out_result <= op_is_rem(op) ? '0 : OVF_QUOT;
                        bus.out_valid  <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        dvd   <= a_abs;
                        dvs   <= b_abs;
                        neg_q <= signed_op & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                        neg_r <= signed_op & a_q[XLEN-1];
                        count <= CNT_W'(XLEN - 1);
                        rem   <= '0;
                        quot  <= '0;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem         <= step_rem;
                    quot[count] <= step_q;
                    count       <= count - 1'b1;
                    if (count == '0) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Remainder sign follows the dividend, quotient sign is
                    // the XOR of operand signs.
                    bus.out_result <= op_is_rem(op) ? (neg_r ? -rem : rem)
                                                    : (neg_q ? -quot : quot);
                    bus.out_valid  <= 1'b1;
                    state          <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: self-checking bench for div_sequencer.
// Expected results come from a reference model using SV integer division
// plus the RISC-V divide-by-zero / overflow rules.
module tb_div_sequencer;
    import div_pkg::*;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    div_if #(.XLEN(32), .TAG_W(5)) bus ();

    div_sequencer #(.XLEN(32), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // Reference: op[1] selects remainder, op[0] selects unsigned.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int model_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // One full transaction: accept, wait for result, optionally stall the
    // consumer for 'hold' cycles, then take the result.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int hold, input logic [31:0] exp_res,
                         input string name);
        int n;
        int exp_lat;
        exp_lat = model_latency(op, a, b);
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
        else n_pass++;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
        else n_pass++;
        n_total++;
        if (bus.out_result !== exp_res) $display("FAIL %s result: got %h want %h", name, bus.out_result, exp_res);
        else n_pass++;
        n_total++;
        if (bus.out_tag !== tag) $display("FAIL %s tag: got %0d want %0d", name, bus.out_tag, tag);
        else n_pass++;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
                bus.out_result !== exp_res || bus.out_tag !== tag)
                $display("FAIL %s hold%0d: got v=%b r=%b busy=%b res=%h tag=%0d want v=1 r=0 busy=1 res=%h tag=%0d",
                         name, i, bus.out_valid, bus.in_ready, bus.busy, bus.out_result, bus.out_tag, exp_res, tag);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL %s release: got v=%b r=%b busy=%b want v=0 r=1 busy=0",
                     name, bus.out_valid, bus.in_ready, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL reset_ctrl: got r=%b v=%b busy=%b want r=1 v=0 busy=0", bus.in_ready, bus.out_valid, bus.busy);
        else n_pass++;
        n_total++;
        if (bus.out_result !== 32'd0 || bus.out_tag !== 5'd0)
            $display("FAIL reset_data: got res=%h tag=%0d want 0/0", bus.out_result, bus.out_tag);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_op(DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,        5'd3,  0, 32'hFFFF_FFFD, "div_m7_2");
        do_op(DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,        5'd4,  0, 32'hFFFF_FFFF, "rem_m7_2");
        do_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd16,       5'd17, 0, 32'h0FFF_FFFF, "divu_16");
        do_op(DIV_OP_REMU, 32'hFFFF_FFFF, 32'd16,       5'd17, 0, 32'h0000_000F, "remu_16");
        do_op(DIV_OP_DIV,  32'd123,       32'd0,        5'd5,  0, 32'hFFFF_FFFF, "div_by0");
        do_op(DIV_OP_REM,  32'd123,       32'd0,        5'd6,  0, 32'd123,       "rem_by0");
        do_op(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, 32'h8000_0000, "div_ovf");
        do_op(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 32'd0,         "rem_ovf");
        do_op(DIV_OP_REM,  32'd7,         32'hFFFF_FFFE, 5'd9, 0, 32'd1,         "rem_7_m2");
    endtask

    task automatic test_hold();
        do_op(DIV_OP_REMU, 32'd1000, 32'd7, 5'd30, 5, 32'd6, "hold");
    endtask

    task automatic test_flush();
        int n;
        bit seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = DIV_OP_DIV;
        bus.in_a     = $urandom;
        bus.in_b     = 32'd3;
        bus.in_tag   = 5'd12;
        @(negedge clk);
        bus.in_valid = 1'b0;
        // After accept edge + k edges the counter reads 32-k; 22 edges -> 10.
        for (n = 0; n < 22; n++) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL flush_calc: got r=%b busy=%b v=%b want r=1 busy=0 v=0", bus.in_ready, bus.busy, bus.out_valid);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL flush_no_result: got out_valid=1 want 0");
        else n_pass++;
        do_op(DIV_OP_DIVU, 32'd100, 32'd7, 5'd1, 0, 32'd14, "after_flush");

        // A request together with flush in IDLE must be dropped.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = DIV_OP_DIVU;
        bus.in_a     = 32'd50;
        bus.in_b     = 32'd5;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        n_total++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL flush_idle: got busy=%b r=%b want busy=0 r=1", bus.busy, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_no_same_cycle_accept();
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = DIV_OP_DIV;
        bus.in_a     = 32'd0;
        bus.in_b     = 32'd0;
        bus.in_tag   = 5'd2;
        @(negedge clk);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        // in_valid stays high through the result handshake.
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        n_total++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL no_same_accept: got busy=%b r=%b v=%b want busy=0 r=1 v=0", bus.busy, bus.in_ready, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       b = 32'h8000_0000 | $urandom;
                4:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            do_op(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 2), model(op, a, b), "rand");
        end
    endtask

    task automatic test_async_reset();
        do_op(DIV_OP_DIVU, 32'd1000, 32'd3, 5'd9, 0, 32'd333, "pre_reset");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = DIV_OP_DIV;
        bus.in_a     = 32'd99999;
        bus.in_b     = 32'd7;
        bus.in_tag   = 5'd22;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL async_reset_ctrl: got r=%b v=%b busy=%b want r=1 v=0 busy=0", bus.in_ready, bus.out_valid, bus.busy);
        else n_pass++;
        n_total++;
        if (bus.out_result !== 32'd0 || bus.out_tag !== 5'd0)
            $display("FAIL async_reset_data: got res=%h tag=%0d want 0/0", bus.out_result, bus.out_tag);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd11, 0, 32'hFFFF_FFF2, "post_reset");
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_tag    = 5'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_flush();
        test_no_same_cycle_accept();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
